rd_pipelined_subtractor: RTL

//  Pipelined WIDTH-bit subtractor: diff = a - b - bin. Borrow chain is resolved by recursive

---
 rtl/rd_pipelined_subtractor.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rd_pipelined_subtractor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rd_pipelined_subtractor
// Description : Pipelined WIDTH-bit subtractor, diff = a - b - bin. The
//               borrow chain is resolved by recursive doubling of
//               generate/propagate pairs, one register per doubling level,
//               behind a valid/ready handshake with a global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_pipelined_subtractor #(
    parameter int WIDTH  = 16,              // power of 2, >= 2
    parameter int LEVELS = $clog2(WIDTH)    // derived, do not override
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Doubling step. Bit i combines with bit i-span; bits below span pass
    // through untouched. Written with whole-vector shifts and a low mask so
    // no variable bit indexing is needed.
    //   g' = g_i | (t_i & g_(i-span))
    //   t' = g_i | (t_i & t_(i-span))
    // ------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] f_low_mask(input int span);
        f_low_mask = ~({WIDTH{1'b1}} << span);
    endfunction

    function automatic logic [WIDTH-1:0] f_gen(input logic [WIDTH-1:0] t_in,
                                               input logic [WIDTH-1:0] g_in,
                                               input int               span);
        logic [WIDTH-1:0] m;
        m     = f_low_mask(span);
        f_gen = (g_in & m) | (~m & (g_in | (t_in & (g_in << span))));
    endfunction

    function automatic logic [WIDTH-1:0] f_prop(input logic [WIDTH-1:0] t_in,
                                                input logic [WIDTH-1:0] g_in,
                                                input int               span);
        logic [WIDTH-1:0] m;
        m      = f_low_mask(span);
        f_prop = (t_in & m) | (~m & (g_in | (t_in & (t_in << span))));
    endfunction

    // ------------------------------------------------------------------------
    // Pipeline state. Stage 0 holds the raw per-bit pairs (after S1); stage
    // s holds the pairs after s doubling levels. The last doubling level is
    // evaluated combinationally and lands directly in the output register.
    // x, bin and the operand sign bits ride along to the output stage.
    // ------------------------------------------------------------------------
    logic [LEVELS-1:0][WIDTH-1:0] g_q, g_d;
    logic [LEVELS-1:0][WIDTH-1:0] t_q, t_d;
    logic [LEVELS-1:0][WIDTH-1:0] x_q, x_d;
    logic [LEVELS-1:0]            bin_q, bin_d;
    logic [LEVELS-1:0]            amsb_q, amsb_d;
    logic [LEVELS-1:0]            bmsb_q, bmsb_d;
    logic [LEVELS-1:0]            vld_q, vld_d;

    logic                         out_valid_q;
    logic [WIDTH-1:0]             diff_q, diff_d;
    logic                         bout_q, bout_d;
    logic                         ovf_q, ovf_d;

    logic                         w_adv;
    logic [WIDTH-1:0]             w_borrow;
    logic [WIDTH-1:0]             w_g_bit;
    logic [WIDTH-1:0]             w_t_bit;
    logic                         w_g0;

    // The whole pipe moves as one: it advances whenever the output slot is
    // empty or being drained this cycle.
    assign w_adv    = ~out_valid_q | out_ready;
    assign in_ready = w_adv;

    // Per-bit borrow generate/propagate; bit 0 absorbs the borrow-in so the
    // resolved g vector is directly the borrow-out of every bit position.
    always_comb begin
        w_g_bit = ~a & b;
        w_t_bit = w_g_bit | ~(a ^ b);
        w_g0    = (~a[0] & b[0]) | (~a[0] & bin) | (b[0] & bin);
        w_g_bit[0] = w_g0;
        w_t_bit[0] = w_g0;
    end

    // Next-state for every pipeline stage: S1 loads from the ports, later
    // stages apply one doubling level each and shift the side-band along.
    always_comb begin
        g_d    = '0;
        t_d    = '0;
        x_d    = '0;
        bin_d  = '0;
        amsb_d = '0;
        bmsb_d = '0;
        vld_d  = '0;

        g_d[0]    = w_g_bit;
        t_d[0]    = w_t_bit;
        x_d[0]    = a ^ b;
        bin_d[0]  = bin;
        amsb_d[0] = a[WIDTH-1];
        bmsb_d[0] = b[WIDTH-1];
        vld_d[0]  = in_valid;

        for (int s = 1; s < LEVELS; s++) begin
            g_d[s]    = f_gen (t_q[s-1], g_q[s-1], 1 << (s - 1));
            t_d[s]    = f_prop(t_q[s-1], g_q[s-1], 1 << (s - 1));
            x_d[s]    = x_q[s-1];
            bin_d[s]  = bin_q[s-1];
            amsb_d[s] = amsb_q[s-1];
            bmsb_d[s] = bmsb_q[s-1];
            vld_d[s]  = vld_q[s-1];
        end
    end

    // Final doubling level plus result formation. Only the generate half of
    // the last level is needed: it is the fully resolved borrow per bit.
    always_comb begin
        w_borrow = f_gen(t_q[LEVELS-1], g_q[LEVELS-1], 1 << (LEVELS - 1));
        diff_d   = x_q[LEVELS-1] ^ {w_borrow[WIDTH-2:0], bin_q[LEVELS-1]};
        bout_d   = w_borrow[WIDTH-1];
        ovf_d    = (amsb_q[LEVELS-1] ^ bmsb_q[LEVELS-1]) &
                   (amsb_q[LEVELS-1] ^ diff_d[WIDTH-1]);
    end

    // Stage data registers; no reset needed because the valid bits qualify
    // them, and a bubble may leave stale data behind.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            g_q    <= g_d;
            t_q    <= t_d;
            x_q    <= x_d;
            bin_q  <= bin_d;
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
        end
    end

    // Stage valid bits; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (w_adv) begin
            vld_q <= vld_d;
        end
    end

    // Output register: holds steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (w_adv) begin
            out_valid_q <= vld_q[LEVELS-1];
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign busy      = (|vld_q) | out_valid_q;

endmodule
`default_nettype wire
